// File: rtl/led_pkg.sv
// Shared definitions for the LED breathing envelope generator.
// State encoding, default widths and the intensity ceiling helper.
package led_pkg;

    localparam int LED_INT_W  = 4;
    localparam int LED_DIV_W  = 16;
    localparam int LED_HOLD_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RISE    = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_FALL    = 3'd3,
        ST_HOLD_LO = 3'd4
    } state_t;

    function automatic int int_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/led_breath_env_if.sv
// Configuration and output bundle of the breathing envelope.
// master drives config and watches the envelope; slave is the generator.
interface led_breath_env_if #(
    parameter int INT_W  = led_pkg::LED_INT_W,
    parameter int DIV_W  = led_pkg::LED_DIV_W,
    parameter int HOLD_W = led_pkg::LED_HOLD_W
);
    logic              en;
    logic [DIV_W-1:0]  step_div;
    logic [HOLD_W-1:0] hold_hi;
    logic [HOLD_W-1:0] hold_lo;
    logic [INT_W-1:0]  intensity;
    logic              int_upd;
    logic [2:0]        phase;
    logic              cycle_done;

    modport master (
        output en, step_div, hold_hi, hold_lo,
        input  intensity, int_upd, phase, cycle_done
    );

    modport slave (
        input  en, step_div, hold_hi, hold_lo,
        output intensity, int_upd, phase, cycle_done
    );
endinterface

// File: rtl/led_step_div.sv
// Step-rate divider: one tick every div+1 clocks while run is high.
// The count is held at zero whenever run is low.
module led_step_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_q;

    assign tick = run && (cnt_q == div);

    // Free-running count that wraps on the tick and clears when stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!run || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/led_breath_env.sv
// Breathing brightness envelope: rise, hold high, fall, hold low.
// Config is sampled only at the start of each envelope cycle.
module led_breath_env #(
    parameter int INT_W  = led_pkg::LED_INT_W,
    parameter int DIV_W  = led_pkg::LED_DIV_W,
    parameter int HOLD_W = led_pkg::LED_HOLD_W
) (
    input  logic           clk,
    input  logic           rst_n,
    led_breath_env_if.slave bus
);
    import led_pkg::*;

    localparam logic [INT_W-1:0] MAX    = INT_W'(int_max(INT_W));
    localparam logic [INT_W-1:0] MAX_M1 = MAX - 1'b1;
    localparam logic [INT_W-1:0] ONE    = INT_W'(1);

    state_t            st_q, st_d;
    logic [INT_W-1:0]  int_q, int_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hold_inc;
    logic [DIV_W-1:0]  div_l;
    logic [HOLD_W-1:0] hhi_l;
    logic [HOLD_W-1:0] hlo_l;
    logic              upd_q, upd_d;
    logic              done_q, done_d;
    logic              latch;
    logic              run;
    logic              tick;

    // The divider only runs in an active state with the enable still high,
    // so dropping en clears the count on the same edge as the FSM.
    assign run      = bus.en && (st_q != ST_IDLE);
    assign hold_inc = hold_q + 1'b1;

    led_step_div #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (run),
        .div  (div_l),
        .tick (tick)
    );

    // Next-state, next-intensity and pulse decode.
    always_comb begin
        st_d   = st_q;
        int_d  = int_q;
        hold_d = hold_q;
        upd_d  = 1'b0;
        done_d = 1'b0;
        latch  = 1'b0;
        if (!bus.en) begin
            st_d   = ST_IDLE;
            int_d  = '0;
            hold_d = '0;
            upd_d  = (int_q != '0);
        end else begin
            case (st_q)
                ST_IDLE: begin
                    st_d   = ST_RISE;
                    int_d  = '0;
                    hold_d = '0;
                    latch  = 1'b1;
                end
                ST_RISE: begin
                    if (tick) begin
                        int_d = int_q + 1'b1;
                        upd_d = 1'b1;
                        if (int_q == MAX_M1) begin
                            hold_d = '0;
                            st_d   = (hhi_l != '0) ? ST_HOLD_HI : ST_FALL;
                        end
                    end
                end
                ST_HOLD_HI: begin
                    if (tick) begin
                        hold_d = hold_inc;
                        if (hold_inc == hhi_l) begin
                            st_d = ST_FALL;
                        end
                    end
                end
                ST_FALL: begin
                    if (tick) begin
                        int_d = int_q - 1'b1;
                        upd_d = 1'b1;
                        if (int_q == ONE) begin
                            if (hlo_l != '0) begin
                                st_d   = ST_HOLD_LO;
                                hold_d = '0;
                            end else begin
                                st_d   = ST_RISE;
                                done_d = 1'b1;
                                latch  = 1'b1;
                            end
                        end
                    end
                end
                ST_HOLD_LO: begin
                    if (tick) begin
                        hold_d = hold_inc;
                        if (hold_inc == hlo_l) begin
                            st_d   = ST_RISE;
                            done_d = 1'b1;
                            latch  = 1'b1;
                        end
                    end
                end
                default: begin
                    st_d   = ST_IDLE;
                    int_d  = '0;
                    hold_d = '0;
                    upd_d  = (int_q != '0);
                end
            endcase
        end
    end

    // State, intensity, hold count and output pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            int_q  <= '0;
            hold_q <= '0;
            upd_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            int_q  <= int_d;
            hold_q <= hold_d;
            upd_q  <= upd_d;
            done_q <= done_d;
        end
    end

    // Config snapshot taken at each envelope start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_l <= '0;
            hhi_l <= '0;
            hlo_l <= '0;
        end else if (latch) begin
            div_l <= bus.step_div;
            hhi_l <= bus.hold_hi;
            hlo_l <= bus.hold_lo;
        end
    end

    assign bus.intensity  = int_q;
    assign bus.int_upd    = upd_q;
    assign bus.phase      = st_q;
    assign bus.cycle_done = done_q;
endmodule

// File: doc/led_breath_env.md
Name: led_breath_env

Overview:
Upstream intensity source for the LED PWM stage. It generates a programmable "breathing" brightness envelope: ramp up, hold at full brightness, ramp down, hold dark, then repeat. It replaces the fixed free-running counter ramp with a state machine whose step rate and hold times are set by configuration. Its intensity output drives the PWM accumulator's intensity input directly.

Parameters:
INT_W, 4, intensity width; MAX = 2^INT_W-1
DIV_W, 16, width of step-rate divider
HOLD_W, 8, width of hold-time counters (in steps)

Ports:
clk        input   1        system clock
rst_n      input   1        asynchronous active-low reset
en         input   1        envelope enable; low forces IDLE
step_div   input   DIV_W    step period minus one, in clk cycles
hold_hi    input   HOLD_W   steps held at MAX; 0 = no hold
hold_lo    input   HOLD_W   steps held at 0; 0 = no hold
intensity  output  INT_W    current brightness, to PWM stage
int_upd    output  1        1-clk pulse on the cycle intensity changes
phase      output  3        current state encoding
cycle_done output  1        1-clk pulse at end of each full envelope

Behaviour:
- Reset (async, rst_n=0): state IDLE, intensity=0, int_upd=0, cycle_done=0, divider count=0, hold count=0, latched config=0.
- States: IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4. Codes 5-7 are unused; if reached, go to IDLE next clk.
- Step tick: internal divider counts clk cycles while state != IDLE. tick=1 when count==div_l, and count then returns to 0; otherwise count+1. Step period is div_l+1 clks.
- Config latch: step_div, hold_hi and hold_lo are latched into div_l, hhi_l and hlo_l on IDLE->RISE and on every re-entry to RISE from HOLD_LO or FALL. Mid-cycle config changes have no effect until the next cycle.
- IDLE: intensity=0. If en=1 at an edge: go to RISE, latch config, count=0.
- RISE: on tick, intensity+1 and int_upd pulses. On the tick where intensity goes MAX-1 -> MAX: go to HOLD_HI (hold=0) if hhi_l!=0, else go to FALL.
- HOLD_HI: intensity=MAX. On tick, hold+1. When hold reaches hhi_l: go to FALL.
- FALL: on tick, intensity-1 and int_upd pulses. On the tick where intensity goes 1 -> 0: go to HOLD_LO if hlo_l!=0. Otherwise go to RISE, pulse cycle_done and relatch config.
- HOLD_LO: intensity=0. On tick, hold+1. When hold reaches hlo_l: go to RISE, pulse cycle_done and relatch config.
- Envelope period: (div_l+1)*(2*MAX + hhi_l + hlo_l) clks.
- Latency:
  - intensity first becomes 1 at the edge div_l+1 clks after the edge that took the block into RISE.
  - int_upd is registered and coincides with the new intensity value.
- en=0 in any state: at the next edge go to IDLE, with intensity=0, count=0 and hold=0. No cycle_done pulse. int_upd pulses if intensity was nonzero.
- en re-asserted: restart from RISE at intensity 0. There is no resume.
- step_div=0: one step per clk.
- Hold counters wrap-safe: compare with equality only. hold is cleared on entry to each hold state.
- All outputs are registered; no combinational input-to-output paths.

Decomposition:
- Package led_pkg:
  - state encoding constants (ST_IDLE..ST_HOLD_LO, 3-bit)
  - default widths INT_W, DIV_W, HOLD_W
  - intensity max expression
- Sub-module led_step_div:
  - ports: clk, rst_n, run, div, tick
  - the divider counter; clears to 0 when run=0
- Top: FSM, intensity register, hold counter, config latches.

Test Plan:
- Reset and idle: rst_n=0 mid-RISE with intensity=7 -> immediately intensity=0, phase=0. Release with en=0 -> stays at intensity=0, phase=0.
- Minimal cycle: step_div=0, hold_hi=0, hold_lo=0, en=1 -> intensity 1..15 then 14..0, with 15 int_upd pulses up and 15 down. cycle_done every 30 clks; phase never 2 or 4.
- Timed holds: step_div=3, hold_hi=2, hold_lo=1 -> first intensity=1 at 4 clks after RISE entry. MAX held 8 clks, 0 held 4 clks, period 4*(30+3)=132 clks.
- Mid-cycle reconfig: change step_div 3->0 during FALL -> step spacing stays 4 clks until cycle_done, then becomes 1 clk.
- Disable mid-operation: en=0 while intensity=9 in FALL -> next edge intensity=0, phase=0, no cycle_done, int_upd=1. Re-enable -> restarts at 0 and reaches 1 after step_div+1 clks.
- Downstream check: connect the PWM stage and run step_div=1023 -> measured LED duty tracks intensity/16 within one PWM period at every step.
